// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates pipeline writeback against a
// long-latency unit and tracks pending long-latency destinations for issue hazards.
module rf_wb_scheduler #(
   parameter int XLEN       = 32,
   parameter int NREG       = 32,
   parameter int STARVE_MAX = 4,
   localparam int AW        = $clog2(NREG),
   localparam int CW        = $clog2(STARVE_MAX + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_valid,
   input  logic            issue_long,
   input  logic [AW-1:0]   issue_rd,
   input  logic [AW-1:0]   issue_rs1,
   input  logic [AW-1:0]   issue_rs2,
   output logic            stall,
   input  logic            pipe_wb_valid,
   input  logic [AW-1:0]   pipe_wb_rd,
   input  logic [XLEN-1:0] pipe_wb_data,
   input  logic            lu_valid,
   input  logic [AW-1:0]   lu_rd,
   input  logic [XLEN-1:0] lu_data,
   output logic            lu_ready,
   output logic            rf_we,
   output logic [AW-1:0]   rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic [NREG-1:0] busy_mask,
   output logic            sb_err
);

   logic            rf_we_q, rf_we_d;
   logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
   logic            src_lu_q, src_lu_d;
   logic [NREG-1:0] busy_q, busy_d;
   logic            sb_err_q, sb_err_d;
   logic [CW-1:0]   starve_q, starve_d;

   logic            lu_xfer;
   logic            starve_hit;
   logic            hazard;
   logic            issue_accept;
   logic [NREG-1:0] set_vec;
   logic [NREG-1:0] clr_vec;

   // Pipeline writeback cannot be held off, so it always owns the port when present.
   always_comb begin
      lu_ready     = lu_valid && !pipe_wb_valid;
      lu_xfer      = lu_valid && lu_ready;
      starve_hit   = (starve_q == CW'(STARVE_MAX));
      hazard       = ((issue_rs1 != '0) && busy_q[issue_rs1]) ||
                     ((issue_rs2 != '0) && busy_q[issue_rs2]) ||
                     ((issue_rd  != '0) && busy_q[issue_rd]);
      stall        = issue_valid && (hazard || starve_hit);
      issue_accept = issue_valid && !stall && issue_long && (issue_rd != '0);
   end

   // A busy bit clears only once the long-unit write is actually on the port.
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
         assign set_vec[gi] = issue_accept && (issue_rd == AW'(gi));
         assign clr_vec[gi] = rf_we_q && src_lu_q && (rf_waddr_q == AW'(gi));
      end
   endgenerate

   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      src_lu_d   = 1'b0;
      if (pipe_wb_valid) begin
         rf_we_d    = (pipe_wb_rd != '0);
         rf_waddr_d = pipe_wb_rd;
         rf_wdata_d = pipe_wb_data;
      end else if (lu_xfer) begin
         rf_we_d    = (lu_rd != '0);
         rf_waddr_d = lu_rd;
         rf_wdata_d = lu_data;
         src_lu_d   = 1'b1;
      end

      busy_d   = (busy_q & ~clr_vec) | set_vec;
      sb_err_d = sb_err_q || (lu_xfer && (lu_rd != '0) && !busy_q[lu_rd]);

      if (!lu_valid || lu_xfer)
         starve_d = '0;
      else if (starve_hit)
         starve_d = starve_q;
      else
         starve_d = starve_q + CW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         src_lu_q   <= 1'b0;
         busy_q     <= '0;
         sb_err_q   <= 1'b0;
         starve_q   <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         src_lu_q   <= src_lu_d;
         busy_q     <= busy_d;
         sb_err_q   <= sb_err_d;
         starve_q   <= starve_d;
      end
   end

   assign rf_we     = rf_we_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign busy_mask = busy_q;
   assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench: expected register-file writes go through a scoreboard queue;
// issue-side and status outputs are checked against hand-computed values.
module tb_rf_wb_scheduler;

   localparam int XLEN = 32;
   localparam int NREG = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            issue_valid, issue_long;
   logic [4:0]      issue_rd, issue_rs1, issue_rs2;
   logic            stall;
   logic            pipe_wb_valid;
   logic [4:0]      pipe_wb_rd;
   logic [XLEN-1:0] pipe_wb_data;
   logic            lu_valid;
   logic [4:0]      lu_rd;
   logic [XLEN-1:0] lu_data;
   logic            lu_ready;
   logic            rf_we;
   logic [4:0]      rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic [NREG-1:0] busy_mask;
   logic            sb_err;

   int checks = 0;
   int errors = 0;
   logic [36:0] exp_q[$];

   rf_wb_scheduler #(.XLEN(XLEN), .NREG(NREG), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_long(issue_long),
      .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .stall(stall),
      .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
      .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .busy_mask(busy_mask), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end else
         $display("ok   %s = %0h", name, act);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid = 0; issue_long = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
      pipe_wb_valid = 0; pipe_wb_rd = 0; pipe_wb_data = 0;
      lu_valid = 0; lu_rd = 0; lu_data = 0;
   endtask

   task automatic issue(input logic lng, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2);
      issue_valid = 1; issue_long = lng; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
   endtask

   task automatic push(input logic [4:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   // Monitor: every write presented on the port must match the oldest expectation.
   always @(negedge clk) begin
      if (reset && rf_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_unexpected actual=%0h:%0h required=none", rf_waddr, rf_wdata);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({rf_waddr, rf_wdata} !== e) begin
               errors++;
               $display("FAIL wb_write actual=%0h:%0h required=%0h:%0h",
                        rf_waddr, rf_wdata, e[36:32], e[31:0]);
            end else
               $display("ok   wb_write %0h:%0h", rf_waddr, rf_wdata);
         end
      end
   end

   initial begin
      idle_inputs();
      reset = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1;
      // Idle cycle after reset
      @(negedge clk);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_busy", busy_mask, 0);
      chk("rst_stall", stall, 0);
      chk("rst_sb_err", sb_err, 0);
      chk("rst_lu_ready", lu_ready, 0);
      tick();

      // Long issue to x5
      issue(1, 5, 1, 2);
      @(negedge clk); chk("issue5_stall", stall, 0);
      tick();
      issue(0, 1, 5, 0);                       // RAW on rs1
      @(negedge clk);
      chk("busy5_set", busy_mask, 32'h20);
      chk("raw_stall_a", stall, 1);
      tick();
      issue(0, 5, 0, 0);                       // WAW on rd
      @(negedge clk); chk("waw_stall_a", stall, 1);
      tick();
      // Transfer cycle t
      issue(0, 1, 5, 0);
      lu_valid = 1; lu_rd = 5; lu_data = 32'hDEADBEEF;
      push(5, 32'hDEADBEEF);
      @(negedge clk);
      chk("xfer_lu_ready", lu_ready, 1);
      chk("raw_stall_t", stall, 1);
      tick();
      // t+1: write on port, still busy
      lu_valid = 0;
      issue(0, 5, 0, 0);
      @(negedge clk);
      chk("waw_stall_t1", stall, 1);
      chk("busy5_t1", busy_mask, 32'h20);
      tick();
      // t+2: released
      issue(0, 1, 5, 0);
      @(negedge clk);
      chk("busy5_clear", busy_mask, 0);
      chk("raw_release", stall, 0);
      tick();
      issue(0, 0, 0, 0);
      @(negedge clk); chk("x0_src_stall", stall, 0);
      tick();

      // Collision: pipe wins, lu granted once pipe drops
      issue(1, 5, 0, 0);
      tick();
      issue_valid = 0;
      pipe_wb_valid = 1; pipe_wb_rd = 3; pipe_wb_data = 32'h11;
      lu_valid = 1; lu_rd = 5; lu_data = 32'h55;
      push(3, 32'h11);
      @(negedge clk); chk("coll_lu_ready", lu_ready, 0);
      tick();
      pipe_wb_valid = 0;
      push(5, 32'h55);
      @(negedge clk); chk("coll_lu_grant", lu_ready, 1);
      tick();
      lu_valid = 0;
      tick();
      @(negedge clk); chk("coll_busy_clear", busy_mask, 0);
      tick();

      // Starvation: stall from the 5th refused cycle
      issue(1, 6, 0, 0);
      tick();
      for (int k = 1; k <= 6; k++) begin
         issue(0, 1, 2, 3);
         pipe_wb_valid = 1; pipe_wb_rd = 5'(k + 8); pipe_wb_data = 32'(k);
         lu_valid = 1; lu_rd = 6; lu_data = 32'h66;
         push(5'(k + 8), 32'(k));
         @(negedge clk);
         chk($sformatf("starve_lu_ready_%0d", k), lu_ready, 0);
         chk($sformatf("starve_stall_%0d", k), stall, (k >= 5) ? 1 : 0);
         tick();
      end
      pipe_wb_valid = 0;
      push(6, 32'h66);
      @(negedge clk);
      chk("starve_grant", lu_ready, 1);
      chk("starve_hold_stall", stall, 1);
      tick();
      lu_valid = 0;
      @(negedge clk); chk("starve_cleared", stall, 0);
      tick();
      issue_valid = 0;
      tick();

      // Error: write to a register that was not busy
      lu_valid = 1; lu_rd = 7; lu_data = 32'h77;
      push(7, 32'h77);
      @(negedge clk);
      chk("err_lu_ready", lu_ready, 1);
      chk("err_pre", sb_err, 0);
      tick();
      lu_valid = 0;
      @(negedge clk); chk("err_set", sb_err, 1);
      tick(); tick();
      @(negedge clk); chk("err_sticky", sb_err, 1);
      tick();

      // Long-unit write to x0 completes without a port write
      lu_valid = 1; lu_rd = 0; lu_data = 32'h99;
      @(negedge clk); chk("x0_lu_ready", lu_ready, 1);
      tick();
      lu_valid = 0;
      @(negedge clk); chk("x0_rf_we", rf_we, 0);
      tick();

      // Asynchronous reset mid-sequence
      issue(1, 9, 0, 0);
      tick();
      issue_valid = 0;
      @(negedge clk); chk("busy9_set", busy_mask, 32'h200);
      #2;
      reset = 0;
      #1;
      chk("arst_busy", busy_mask, 0);
      chk("arst_sb_err", sb_err, 0);
      chk("arst_rf_we", rf_we, 0);
      tick();
      reset = 1;
      tick();
      @(negedge clk);
      chk("post_rst_stall", stall, 0);
      chk("queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Schedules the single register-file write port (WE3/A3/WD3) between two sources: in-order pipeline writeback, and a long-latency unit (loads/multi-cycle ops) that uses a valid/ready handshake.
- Keeps a per-register busy scoreboard for long-latency destinations and stalls issue on RAW/WAW hazards against those pending registers.
- Sits between the decode stage (issue side) and the RegisterFile write port.

Parameters:
- XLEN, 32, data width of writeback values.
- NREG, 32, number of architectural registers (address width is log2(NREG) = 5).
- STARVE_MAX, 4, consecutive refused cycles of a long-unit request before issue is forced to stall so the pipeline drains.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_long  in  1  that instruction's result comes from the long-latency unit.
- issue_rd  in  5  destination register.
- issue_rs1  in  5  source register 1.
- issue_rs2  in  5  source register 2.
- stall  out  1  issue blocked this cycle (combinational).
- pipe_wb_valid  in  1  pipeline writeback request; cannot be backpressured.
- pipe_wb_rd  in  5  pipeline writeback destination.
- pipe_wb_data  in  XLEN  pipeline writeback data.
- lu_valid  in  1  long-unit result valid.
- lu_rd  in  5  long-unit result destination.
- lu_data  in  XLEN  long-unit result data.
- lu_ready  out  1  long-unit result accepted this cycle (combinational).
- rf_we  out  1  to RegisterFile WE3 (registered).
- rf_waddr  out  5  to RegisterFile A3 (registered).
- rf_wdata  out  XLEN  to RegisterFile WD3 (registered).
- busy_mask  out  NREG  scoreboard state (registered).
- sb_err  out  1  sticky error: long-unit wrote a register that was not busy.

Behaviour:
- Reset (reset=0, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0, sb_err=0, starve counter=0.
  - Combinational outputs follow from the cleared state.
  - A reset mid-operation discards all pending entries; the long unit is expected to be reset by the same reset.
- Arbitration (combinational, cycle t):
  - pipe_wb_valid=1 wins the port; lu_ready=0.
  - Otherwise lu_ready = lu_valid.
  - A transfer happens when lu_valid && lu_ready.
- Write port (registered, 1-cycle latency):
  - At the edge ending cycle t, the granted source is captured into rf_waddr/rf_wdata.
  - rf_we is set to 1 in cycle t+1, except when the captured address is 0: rf_we=0 in that case, but the long-unit transfer still completes.
  - With no grant, rf_we=0 and address/data hold their previous values.
- Scoreboard:
  - Set busy[issue_rd] on an accepted issue: issue_valid && !stall && issue_long && issue_rd!=0.
  - Clear busy[rf_waddr] at the edge ending the cycle in which the registered rf_we=1 and that write came from the long unit (track with a registered source flag).
  - The dependent instruction is therefore released in cycle t+2, after the RegisterFile has written.
  - If a set and a clear hit the same index in the same cycle, set wins.
- Stall:
  - stall = issue_valid && (hazard || starve_hit).
  - hazard = any of busy[rs1], busy[rs2], busy[rd], each considered only for a nonzero index.
  - busy[rd] covers WAW.
- Starvation:
  - The counter increments each cycle lu_valid && !lu_ready, saturating at STARVE_MAX.
  - It resets to 0 on any long-unit transfer, or when lu_valid=0.
  - starve_hit = (count == STARVE_MAX).
  - While starve_hit holds, stall stays asserted; the pipeline drains, pipe_wb_valid drops, and the long unit is granted.
- sb_err: set when a long-unit transfer has lu_rd!=0 and busy[lu_rd]=0 in the transfer cycle; cleared only by reset.
- Pipeline writeback never touches the scoreboard.

Test Plan:
- Reset, then one idle cycle -> rf_we=0, busy_mask=0, stall=0, sb_err=0, lu_ready=0.
- Issue long rd=5; three cycles later lu_valid, rd=5, data=0xDEADBEEF with no pipe traffic:
  - busy_mask[5]=1 from the next cycle;
  - lu_ready=1 in the transfer cycle t; rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in t+1;
  - busy_mask[5]=0 in t+2.
- Same-register hazards with busy[5]=1:
  - issue rs1=5 -> stall=1 each cycle until t+2, then stall=0;
  - issue rd=5 (WAW) -> stall=1 for the same cycles;
  - issue rs1=0 with busy[0] never set -> stall=0.
- Collision: pipe_wb_valid=1 (rd=3, data=0x11) and lu_valid=1 (rd=5) in the same cycle:
  - lu_ready=0; next cycle rf_waddr=3, rf_wdata=0x11;
  - lu is granted the first cycle pipe_wb_valid=0.
- Starvation with STARVE_MAX=4: pipe_wb_valid held 1 while lu_valid=1 -> stall=1 with issue_valid=1 from the 5th refused cycle; once pipe_wb_valid drops, lu_ready=1 and the counter returns to 0.
- Error and x0 handling:
  - lu transfer to rd=7 with busy[7]=0 -> sb_err=1 and it stays 1.
  - lu transfer to rd=0 -> lu_ready=1 and rf_we=0 next cycle.
  - Asserting reset mid-sequence -> busy_mask=0 and sb_err=0 immediately.
